// File: rtl/mips_ifetch.sv
// Instruction-fetch stage for the 32x32 instruction pROM.
// Owns the PC and drives the pROM read port. It absorbs the pROM's one-cycle
// read latency and hands {instr, pc} to decode through a 2-entry skid buffer.
// A branch/jump redirect flushes the buffer and refetches from the target.
module mips_ifetch #(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  // pROM read port
  output logic [ADDR_W-1:0] rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  input  logic [31:0]       rom_dout,
  // Branch/jump redirect
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  // Decode handshake
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  // Architectural state
  logic [31:0] r_fetch_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic [1:0]  r_count;

  // Skid buffer. Slot 0 is always the head.
  logic [31:0] r_instr0;
  logic [31:0] r_pc0;
  logic [31:0] r_instr1;
  logic [31:0] r_pc1;

  // Combinational control
  logic [31:0] w_req_pc;
  logic        w_pop;
  logic [1:0]  w_occ;
  logic        w_issue;
  logic        w_capture;
  logic        w_wr_slot1;

  // Next-state values for the buffer
  logic [1:0]  w_count_nxt;
  logic [31:0] w_instr0_nxt;
  logic [31:0] w_pc0_nxt;
  logic [31:0] w_instr1_nxt;
  logic [31:0] w_pc1_nxt;

  assign rom_oce   = 1'b1;
  assign rom_reset = 1'b0;

  assign if_valid = (r_count != 2'd0);
  assign if_instr = r_instr0;
  assign if_pc    = r_pc0;

  assign w_pop = if_valid && if_ready;

  // Buffered words plus the word now on rom_dout. The issue rule keeps this at 2 or less.
  assign w_occ = r_count + {1'b0, r_inflight};

  // Request, issue and capture decisions for this cycle
  always_comb begin
    w_req_pc = r_fetch_pc;
    if (redirect_valid) begin
      w_req_pc = redirect_pc & 32'hFFFF_FFFC;
    end

    // Issue only when the word will have a slot when it lands.
    // reset_n is included so the enable drops as soon as reset is asserted.
    w_issue = reset_n && (redirect_valid || (w_occ < 2'd2) || (w_pop && (w_occ == 2'd2)));

    // During a redirect cycle the word on rom_dout belongs to the old path.
    // It is dropped here, so the target read issued this edge is kept.
    w_capture = r_inflight && !redirect_valid;

    // The tail slot is counted after any pop in the same edge.
    w_wr_slot1 = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);
  end

  assign rom_ce = w_issue;
  assign rom_ad = w_req_pc[ADDR_W+1:2];

  // Buffer next state: pop shifts slot 1 into slot 0, then capture fills the tail
  always_comb begin
    w_count_nxt  = r_count;
    w_instr0_nxt = r_instr0;
    w_pc0_nxt    = r_pc0;
    w_instr1_nxt = r_instr1;
    w_pc1_nxt    = r_pc1;

    if (w_pop) begin
      w_instr0_nxt = r_instr1;
      w_pc0_nxt    = r_pc1;
    end

    if (w_capture) begin
      if (w_wr_slot1) begin
        w_instr1_nxt = rom_dout;
        w_pc1_nxt    = r_inflight_pc;
      end else begin
        w_instr0_nxt = rom_dout;
        w_pc0_nxt    = r_inflight_pc;
      end
    end

    case ({w_pop, w_capture})
      2'b10:   w_count_nxt = r_count - 2'd1;
      2'b01:   w_count_nxt = r_count + 2'd1;
      default: w_count_nxt = r_count;
    endcase

    // A redirect flushes everything, including an entry popped in the same edge
    if (redirect_valid) begin
      w_count_nxt = 2'd0;
    end
  end

  // PC and in-flight tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc    <= RESET_PC_ALIGNED;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= w_req_pc + 32'd4;
        r_inflight_pc <= w_req_pc;
      end
    end
  end

  // Skid buffer storage and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= 2'd0;
      r_instr0 <= 32'h0;
      r_pc0    <= 32'h0;
      r_instr1 <= 32'h0;
      r_pc1    <= 32'h0;
    end else begin
      r_count  <= w_count_nxt;
      r_instr0 <= w_instr0_nxt;
      r_pc0    <= w_pc0_nxt;
      r_instr1 <= w_instr1_nxt;
      r_pc1    <= w_pc1_nxt;
    end
  end

endmodule

// File: tb/tb_mips_ifetch.sv
// Bench for mips_ifetch. A behavioural pROM returns C0DE0000+word with a
// one-cycle latency. Stimulus pushes the expected accepted stream into queues.
// A negedge monitor pops and compares on every valid&&ready handshake.
module tb_mips_ifetch;

  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] rom_ad;
  logic              rom_ce;
  logic              rom_oce;
  logic              rom_reset;
  logic [31:0]       rom_dout = 32'h0;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] mon_pc;
  logic [31:0] mon_instr;

  mips_ifetch #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rom_ad        (rom_ad),
    .rom_ce        (rom_ce),
    .rom_oce       (rom_oce),
    .rom_reset     (rom_reset),
    .rom_dout      (rom_dout),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc)
  );

  always #5 clk = ~clk;

  // Behavioural pROM with a synchronous one-cycle read
  always @(posedge clk) begin
    if (rom_ce) rom_dout <= 32'hC0DE_0000 + {{(32 - ADDR_W){1'b0}}, rom_ad};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected entry: a 32-entry pROM aliases every 128 bytes
  task automatic push(input logic [31:0] pc);
    exp_pc_q.push_back(pc);
    exp_instr_q.push_back(32'hC0DE_0000 + {27'b0, pc[6:2]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare every accepted head entry against the queue
  always @(negedge clk) begin
    if (reset_n && if_valid && if_ready) begin
      if (exp_pc_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got pc %h instr %h, want none", if_pc, if_instr);
      end else begin
        mon_pc    = exp_pc_q.pop_front();
        mon_instr = exp_instr_q.pop_front();
        check("stream_pc", if_pc, mon_pc);
        check("stream_instr", if_instr, mon_instr);
      end
    end
  end

  initial begin
    reset_n        = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #2 reset_n = 1'b0;
    step();
    step();

    // Reset state
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_rom_ce", {31'b0, rom_ce}, 32'd0);
    check("rst_rom_oce", {31'b0, rom_oce}, 32'd1);
    check("rst_rom_reset", {31'b0, rom_reset}, 32'd0);

    // Phase A: streaming from reset, including the 128-byte alias
    for (int k = 0; k < 40; k++) push(32'(4 * k));
    reset_n = 1'b1;                                        // cycle 0
    #1;
    check("a0_rom_ce", {31'b0, rom_ce}, 32'd1);
    check("a0_rom_ad", {27'b0, rom_ad}, 32'd0);
    step();                                                // cycle 1
    check("a1_if_valid", {31'b0, if_valid}, 32'd0);
    step();                                                // cycle 2
    check("a2_if_valid", {31'b0, if_valid}, 32'd1);
    check("a2_if_pc", if_pc, 32'h0);
    check("a2_if_instr", if_instr, 32'hC0DE_0000);
    repeat (31) step();                                    // cycle 33
    check("a33_rom_ad_alias", {27'b0, rom_ad}, 32'd1);
    repeat (9) step();                                     // cycle 42

    // Reset asserted mid-stream
    reset_n = 1'b0;
    #1;
    check("midrst_if_valid", {31'b0, if_valid}, 32'd0);
    check("midrst_rom_ce", {31'b0, rom_ce}, 32'd0);
    check("midrst_if_pc", if_pc, 32'h0);
    step();
    check("phase_a_drained", 32'(exp_pc_q.size()), 32'd0);

    // Phase B: restart, stall, redirects
    push(32'h00); push(32'h04); push(32'h08); push(32'h0C);
    push(32'h10); push(32'h14); push(32'h18); push(32'h1C);
    push(32'h20); push(32'h24);
    push(32'h28); push(32'h2C); push(32'h30); push(32'h34);
    push(32'h44); push(32'h48); push(32'h4C);
    reset_n = 1'b1;                                        // cycle 0
    step();
    step();                                                // cycle 2
    check("b2_if_valid", {31'b0, if_valid}, 32'd1);
    check("b2_if_pc", if_pc, 32'h0);
    repeat (4) step();                                     // cycle 6

    // Stall with pc 0x10 at the head for cycles 6..10
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      if_ready = 1'b0;
      check("stall_if_valid", {31'b0, if_valid}, 32'd1);
      check("stall_if_pc", if_pc, 32'h10);
      check("stall_if_instr", if_instr, 32'hC0DE_0004);
      if (i >= 2) check("stall_rom_ce", {31'b0, rom_ce}, 32'd0);
    end
    step();                                                // cycle 11
    if_ready = 1'b1;
    repeat (5) step();                                     // cycle 16

    // Redirect while streaming, target 0x2B -> 0x28
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_002B;
    #1;
    check("redir_rom_ce", {31'b0, rom_ce}, 32'd1);
    check("redir_rom_ad", {27'b0, rom_ad}, 32'd10);
    step();                                                // cycle 17
    redirect_valid = 1'b0;
    check("redir_n1_if_valid", {31'b0, if_valid}, 32'd0);
    step();                                                // cycle 18
    check("redir_n2_if_valid", {31'b0, if_valid}, 32'd1);
    check("redir_n2_if_pc", if_pc, 32'h28);
    check("redir_n2_if_instr", if_instr, 32'hC0DE_000A);
    repeat (4) step();                                     // cycle 22

    // Fill the buffer under stall, then redirect to 0x45 -> 0x44
    if_ready = 1'b0;
    step();                                                // cycle 23
    check("full_rom_ce", {31'b0, rom_ce}, 32'd0);
    check("full_if_pc", if_pc, 32'h38);
    step();                                                // cycle 24
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0045;
    #1;
    check("full_redir_rom_ce", {31'b0, rom_ce}, 32'd1);
    step();                                                // cycle 25
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    check("full_redir_n1_if_valid", {31'b0, if_valid}, 32'd0);
    step();                                                // cycle 26
    check("full_redir_n2_if_valid", {31'b0, if_valid}, 32'd1);
    check("full_redir_n2_if_pc", if_pc, 32'h44);
    check("full_redir_n2_if_instr", if_instr, 32'hC0DE_0011);
    repeat (2) step();                                     // cycle 28
    step();                                                // cycle 29
    if_ready = 1'b0;
    repeat (3) step();

    check("queue_empty", 32'(exp_pc_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
